// File: rtl/cmos_dvp_capture_pkg.sv
// Shared types and constants for the OV5640 DVP capture path.
// State encoding, counter width and default display window.
package cmos_pkg;

    typedef enum logic {
        S_SKIP   = 1'b0,
        S_ACTIVE = 1'b1
    } state_e;

    localparam int CNT_W         = 12;
    localparam int DEF_SRC_WIDTH = 1024;
    localparam int DEF_H_START   = 0;
    localparam int DEF_H_ACTIVE  = 800;
    localparam int DEF_V_START   = 0;
    localparam int DEF_V_ACTIVE  = 480;

    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] v
    );
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/cmos_dvp_capture_if.sv
// Sensor pad bus in, cropped RGB565 pixel stream out.
// slave = capture block, master = sensor/FIFO side.
interface cmos_dvp_capture_if;

    logic        cmos_vsync;
    logic        cmos_href;
    logic [7:0]  cmos_data;
    logic [15:0] pix_data;
    logic        pix_en;
    logic        pix_vs;
    logic [15:0] frame_cnt;
    logic        line_err;

    modport master (
        output cmos_vsync, cmos_href, cmos_data,
        input  pix_data, pix_en, pix_vs, frame_cnt, line_err
    );

    modport slave (
        input  cmos_vsync, cmos_href, cmos_data,
        output pix_data, pix_en, pix_vs, frame_cnt, line_err
    );

endinterface

// File: rtl/dvp_byte_pack.sv
// Pad register stage and high/low byte pairing into 16-bit words.
// Word is combinational from the registered bytes, valid on phase 1.
module dvp_byte_pack #(
    parameter int VS_POL = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmos_vsync,
    input  logic        cmos_href,
    input  logic [7:0]  cmos_data,
    output logic        vs,
    output logic        vs_rise,
    output logic        href,
    output logic        href_fall,
    output logic [15:0] word,
    output logic        word_vld,
    output logic        odd_err
);

    localparam bit POL = (VS_POL != 0);

    logic       vs_q, vs_d;
    logic       vs2_q, vs2_d;
    logic       href_q, href_d;
    logic       href2_q, href2_d;
    logic [7:0] data_q, data_d;
    logic [7:0] hi_q, hi_d;
    logic       phase_q, phase_d;

    always_comb begin
        vs_d    = (cmos_vsync == POL);
        vs2_d   = vs_q;
        href_d  = cmos_href;
        href2_d = href_q;
        data_d  = cmos_data;
        hi_d    = hi_q;
        phase_d = href_q ? ~phase_q : 1'b0;
        if (href_q && !phase_q) begin
            hi_d = data_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q    <= 1'b0;
            vs2_q   <= 1'b0;
            href_q  <= 1'b0;
            href2_q <= 1'b0;
            data_q  <= '0;
            hi_q    <= '0;
            phase_q <= 1'b0;
        end else begin
            vs_q    <= vs_d;
            vs2_q   <= vs2_d;
            href_q  <= href_d;
            href2_q <= href2_d;
            data_q  <= data_d;
            hi_q    <= hi_d;
            phase_q <= phase_d;
        end
    end

    // phase still set after href drops means the line ended on a high byte
    assign vs        = vs_q;
    assign vs_rise   = vs_q & ~vs2_q;
    assign href      = href_q;
    assign href_fall = href2_q & ~href_q;
    assign word      = {hi_q, data_q};
    assign word_vld  = href_q & phase_q;
    assign odd_err   = href_fall & phase_q;

endmodule

// File: rtl/cmos_dvp_capture.sv
// DVP capture top: frame skip FSM, x/y counters, crop window,
// registered pixel stream and line length checking.
module cmos_dvp_capture
    import cmos_pkg::*;
#(
    parameter int SKIP_FRAMES = 2,
    parameter int SRC_WIDTH   = DEF_SRC_WIDTH,
    parameter int H_START     = DEF_H_START,
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int V_START     = DEF_V_START,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int VS_POL      = 1
) (
    input logic               cmos_pclk,
    input logic               rst_n,
    cmos_dvp_capture_if.slave bus
);

    logic        vs, vs_rise, href, href_fall;
    logic [15:0] word;
    logic        word_vld, odd_err;

    dvp_byte_pack #(
        .VS_POL (VS_POL)
    ) u_pack (
        .clk        (cmos_pclk),
        .rst_n      (rst_n),
        .cmos_vsync (bus.cmos_vsync),
        .cmos_href  (bus.cmos_href),
        .cmos_data  (bus.cmos_data),
        .vs         (vs),
        .vs_rise    (vs_rise),
        .href       (href),
        .href_fall  (href_fall),
        .word       (word),
        .word_vld   (word_vld),
        .odd_err    (odd_err)
    );

    state_e           state_q, state_d;
    logic [7:0]       skip_cnt_q, skip_cnt_d;
    logic [CNT_W-1:0] x_q, x_d;
    logic [CNT_W-1:0] y_q, y_d;
    logic [15:0]      pix_data_q, pix_data_d;
    logic             pix_en_q, pix_en_d;
    logic             pix_vs_q, pix_vs_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;
    logic             line_err_q, line_err_d;
    logic             act, x_in, y_in;

    always_comb begin
        state_d     = state_q;
        skip_cnt_d  = skip_cnt_q;
        x_d         = x_q;
        y_d         = y_q;
        pix_data_d  = pix_data_q;
        pix_en_d    = 1'b0;
        pix_vs_d    = 1'b0;
        frame_cnt_d = frame_cnt_q;
        line_err_d  = 1'b0;

        if (state_q == S_SKIP && vs_rise) begin
            if (skip_cnt_q == 8'(SKIP_FRAMES)) begin
                state_d = S_ACTIVE;
            end else begin
                skip_cnt_d = skip_cnt_q + 8'd1;
            end
        end

        if (!href) begin
            x_d = '0;
        end else if (word_vld) begin
            x_d = sat_inc(x_q);
        end

        if (vs_rise) begin
            y_d = '0;
        end else if (href_fall) begin
            y_d = sat_inc(y_q);
        end

        act  = (state_q == S_ACTIVE);
        x_in = (int'(x_q) >= H_START)
            && (int'(x_q) < H_START + H_ACTIVE);
        y_in = (int'(y_q) >= V_START)
            && (int'(y_q) < V_START + V_ACTIVE);

        pix_en_d = word_vld & x_in & y_in & act;
        if (pix_en_d) begin
            pix_data_d = word;
        end
        pix_vs_d = act & vs;

        // the rise that opens output already starts a forwarded frame
        if (vs_rise && state_d == S_ACTIVE) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end

        line_err_d = href_fall
            & ((int'(x_q) != SRC_WIDTH) | odd_err);
    end

    always_ff @(posedge cmos_pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_SKIP;
            skip_cnt_q  <= '0;
            x_q         <= '0;
            y_q         <= '0;
            pix_data_q  <= '0;
            pix_en_q    <= 1'b0;
            pix_vs_q    <= 1'b0;
            frame_cnt_q <= '0;
            line_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            skip_cnt_q  <= skip_cnt_d;
            x_q         <= x_d;
            y_q         <= y_d;
            pix_data_q  <= pix_data_d;
            pix_en_q    <= pix_en_d;
            pix_vs_q    <= pix_vs_d;
            frame_cnt_q <= frame_cnt_d;
            line_err_q  <= line_err_d;
        end
    end

    assign bus.pix_data  = pix_data_q;
    assign bus.pix_en    = pix_en_q;
    assign bus.pix_vs    = pix_vs_q;
    assign bus.frame_cnt = frame_cnt_q;
    assign bus.line_err  = line_err_q;

endmodule

// File: tb/tb_cmos_dvp_capture.sv
// Directed bench for cmos_dvp_capture: three parameterisations
// share one pad stream (C sees an inverted vsync).
module tb_cmos_dvp_capture;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       href = 1'b0;
    logic [7:0] data = 8'h00;
    logic       vs_ab = 1'b0;
    logic       vs_c = 1'b1;

    int checks = 0;
    int passes = 0;

    int cnt_a = 0, cnt_b = 0, err_a = 0, err_b = 0, vs_a = 0;
    logic [15:0] last_b = 16'h0;
    int base_cnt, base_err;

    always #5 clk = ~clk;

    cmos_dvp_capture_if ifa ();
    cmos_dvp_capture_if ifb ();
    cmos_dvp_capture_if ifc ();

    assign ifa.cmos_vsync = vs_ab;
    assign ifa.cmos_href  = href;
    assign ifa.cmos_data  = data;
    assign ifb.cmos_vsync = vs_ab;
    assign ifb.cmos_href  = href;
    assign ifb.cmos_data  = data;
    assign ifc.cmos_vsync = vs_c;
    assign ifc.cmos_href  = href;
    assign ifc.cmos_data  = data;

    cmos_dvp_capture #(
        .SKIP_FRAMES (2), .SRC_WIDTH (4),
        .H_START (0), .H_ACTIVE (4),
        .V_START (0), .V_ACTIVE (2), .VS_POL (1)
    ) u_a (.cmos_pclk (clk), .rst_n (rst_n), .bus (ifa));

    cmos_dvp_capture #(
        .SKIP_FRAMES (0), .SRC_WIDTH (6),
        .H_START (1), .H_ACTIVE (4),
        .V_START (1), .V_ACTIVE (2), .VS_POL (1)
    ) u_b (.cmos_pclk (clk), .rst_n (rst_n), .bus (ifb));

    cmos_dvp_capture #(
        .SKIP_FRAMES (0), .SRC_WIDTH (4),
        .H_START (0), .H_ACTIVE (4),
        .V_START (0), .V_ACTIVE (2), .VS_POL (0)
    ) u_c (.cmos_pclk (clk), .rst_n (rst_n), .bus (ifc));

    always @(negedge clk) begin
        if (ifa.pix_en) cnt_a <= cnt_a + 1;
        if (ifb.pix_en) begin
            cnt_b  <= cnt_b + 1;
            last_b <= ifb.pix_data;
        end
        if (ifa.line_err) err_a <= err_a + 1;
        if (ifb.line_err) err_b <= err_b + 1;
        if (ifa.pix_vs) vs_a <= vs_a + 1;
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            href = 1'b0;
        end
    endtask

    task automatic send_line(input int n, input logic [7:0] hi,
                             input bit extra);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            href = 1'b1;
            data = hi;
            @(negedge clk);
            data = 8'(i);
        end
        if (extra) begin
            @(negedge clk);
            data = 8'hEE;
        end
        idle(4);
    endtask

    task automatic vsync_pulse();
        @(negedge clk);
        vs_ab = 1'b1;
        vs_c  = 1'b0;
        repeat (2) @(negedge clk);
        @(negedge clk);
        vs_ab = 1'b0;
        vs_c  = 1'b1;
        idle(3);
    endtask

    task automatic frame_a();
        vsync_pulse();
        send_line(4, 8'h00, 1'b0);
        send_line(4, 8'h01, 1'b0);
    endtask

    initial begin
        // reset with a busy bus
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            href = ~href;
            data = 8'($urandom);
            vs_ab = (i < 6) ? ~vs_ab : 1'b0;
        end
        @(negedge clk);
        chk("rst_pix_data", ifa.pix_data, 16'h0);
        chk("rst_pix_en", ifa.pix_en, 1'b0);
        chk("rst_pix_vs", ifa.pix_vs, 1'b0);
        chk("rst_frame_cnt", ifa.frame_cnt, 16'h0);
        chk("rst_line_err", ifa.line_err, 1'b0);
        chk("rst_b_pix_en", ifb.pix_en, 1'b0);
        chk("rst_b_frame_cnt", ifb.frame_cnt, 16'h0);

        // release mid-line
        vs_ab = 1'b0;
        href = 1'b1;
        data = 8'h55;
        @(negedge clk);
        rst_n = 1'b1;
        data = 8'h66;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            data = 8'(i);
        end
        idle(4);

        // skip two frames, third is forwarded
        frame_a();
        frame_a();
        chk("skip_no_strobes", 32'(cnt_a), 32'd0);
        chk("skip_no_vs", 32'(vs_a), 32'd0);
        chk("skip_frame_cnt0", ifa.frame_cnt, 16'h0);
        frame_a();
        chk("frame3_strobes", 32'(cnt_a), 32'd8);
        chk("frame3_frame_cnt", ifa.frame_cnt, 16'd1);

        // pairing and two-edge latency
        vsync_pulse();
        base_err = err_a;
        @(negedge clk);
        href = 1'b1;
        data = 8'h12;
        @(negedge clk);
        data = 8'h34;
        @(negedge clk);
        chk("lat_en_early", ifa.pix_en, 1'b0);
        data = 8'hAB;
        @(negedge clk);
        chk("lat_en", ifa.pix_en, 1'b1);
        chk("lat_data", ifa.pix_data, 16'h1234);
        data = 8'hCD;
        @(negedge clk);
        chk("lat_en_low", ifa.pix_en, 1'b0);
        chk("lat_hold", ifa.pix_data, 16'h1234);
        data = 8'h00;
        @(negedge clk);
        data = 8'h11;
        @(negedge clk);
        data = 8'h22;
        @(negedge clk);
        data = 8'h33;
        idle(4);
        chk("lat_last", ifa.pix_data, 16'h2233);
        chk("good_line_no_err", 32'(err_a - base_err), 32'd0);
        chk("frame4_frame_cnt", ifa.frame_cnt, 16'd2);

        // crop window on B
        base_cnt = cnt_b;
        base_err = err_b;
        vsync_pulse();
        for (int l = 0; l < 4; l++) send_line(6, 8'(l), 1'b0);
        chk("crop_strobes", 32'(cnt_b - base_cnt), 32'd8);
        chk("crop_last", last_b, 16'h0204);
        chk("crop_no_err", 32'(err_b - base_err), 32'd0);

        // short line with a dangling byte
        base_cnt = cnt_b;
        base_err = err_b;
        vsync_pulse();
        send_line(6, 8'h00, 1'b0);
        send_line(5, 8'h01, 1'b1);
        chk("odd_err_pulse", 32'(err_b - base_err), 32'd1);
        chk("odd_strobes", 32'(cnt_b - base_cnt), 32'd4);
        chk("odd_hold", ifb.pix_data, 16'h0104);

        // active-low vsync on C
        @(negedge clk);
        vs_c = 1'b0;
        @(negedge clk);
        chk("pol_t1", ifc.pix_vs, 1'b0);
        @(negedge clk);
        chk("pol_t2", ifc.pix_vs, 1'b1);
        @(negedge clk);
        vs_c = 1'b1;
        chk("pol_t3", ifc.pix_vs, 1'b1);
        @(negedge clk);
        chk("pol_t4", ifc.pix_vs, 1'b1);
        @(negedge clk);
        chk("pol_t5", ifc.pix_vs, 1'b0);

        idle(4);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
